// File: rtl/ucsbece154b_line_fetcher_pkg.sv
// Shared types and helpers for the cache-line fetcher.
// Imported by the fetcher interface and the fetcher itself.
package ucsbece154b_line_fetcher_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAddr  = 2'd1,
      StData  = 2'd2,
      StDrain = 2'd3
   } state_e;

   function automatic int unsigned off_width(input int unsigned words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/ucsbece154b_line_fetcher_if.sv
// Request, memory burst and FIFO push signals of the line fetcher.
// master is the fetcher's view; slave is the surrounding system's view.
interface ucsbece154b_line_fetcher_if
   import ucsbece154b_line_fetcher_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned WORDS_PER_LINE = 4
) ();

   localparam int unsigned Off = off_width(WORDS_PER_LINE);

   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic                  flush_i;
   logic                  mem_req_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_ack_i;
   logic                  mem_rvalid_i;
   logic                  mem_rready_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic [DATA_WIDTH-1:0] fifo_data_o;
   logic                  fifo_push_o;
   logic                  fifo_full_i;
   logic [Off-1:0]        word_idx_o;
   logic                  busy_o;
   logic                  done_o;

   modport master (
      input  req_valid_i, req_addr_i, flush_i, mem_ack_i, mem_rvalid_i, mem_rdata_i,
             fifo_full_i,
      output req_ready_o, mem_req_o, mem_addr_o, mem_rready_o, fifo_data_o, fifo_push_o,
             word_idx_o, busy_o, done_o
   );

   modport slave (
      output req_valid_i, req_addr_i, flush_i, mem_ack_i, mem_rvalid_i, mem_rdata_i,
             fifo_full_i,
      input  req_ready_o, mem_req_o, mem_addr_o, mem_rready_o, fifo_data_o, fifo_push_o,
             word_idx_o, busy_o, done_o
   );

endinterface

// File: rtl/ucsbece154b_line_fetcher.sv
// Cache-line fetcher: one burst read per request, beats arrive critical-word-first and are
// pushed into the word FIFO; a flush drains the committed burst without pushing.
module ucsbece154b_line_fetcher
   import ucsbece154b_line_fetcher_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input logic                           clk_i,
   input logic                           rst_i,
   ucsbece154b_line_fetcher_if.master    bus
);

   localparam int unsigned Off  = off_width(WORDS_PER_LINE);
   localparam int unsigned CntW = Off + 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(WORDS_PER_LINE - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [Off-1:0]        word_idx_q, word_idx_d;
   logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;
   logic                  done_q, done_d;

   // Byte-lane bits never reach memory.
   logic unused_byte_bits;
   assign unused_byte_bits = ^bus.req_addr_i[1:0];

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_idx_d = word_idx_q;
      beat_cnt_d = beat_cnt_q;
      done_d     = 1'b0;

      bus.req_ready_o  = 1'b0;
      bus.mem_req_o    = 1'b0;
      bus.mem_addr_o   = '0;
      bus.mem_rready_o = 1'b0;
      bus.fifo_push_o  = 1'b0;
      bus.fifo_data_o  = '0;
      bus.word_idx_o   = '0;

      unique case (state_q)
         StIdle: begin
            bus.req_ready_o = !bus.flush_i;
            if (bus.req_valid_i && !bus.flush_i) begin
               addr_d     = {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
               word_idx_d = bus.req_addr_i[Off+1:2];
               state_d    = StAddr;
            end
         end
         StAddr: begin
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = addr_q;
            if (bus.mem_ack_i) begin
               // Once acked the burst is committed, so a flush must still drain it.
               beat_cnt_d = '0;
               word_idx_d = addr_q[Off+1:2];
               state_d    = bus.flush_i ? StDrain : StData;
            end else if (bus.flush_i) begin
               state_d = StIdle;
            end
         end
         StData: begin
            bus.mem_rready_o = !bus.fifo_full_i && !bus.flush_i;
            bus.word_idx_o   = word_idx_q;
            if (bus.flush_i) begin
               state_d = StDrain;
            end else if (bus.mem_rvalid_i && !bus.fifo_full_i) begin
               bus.fifo_push_o = 1'b1;
               bus.fifo_data_o = bus.mem_rdata_i;
               beat_cnt_d      = beat_cnt_q + 1'b1;
               word_idx_d      = word_idx_q + 1'b1;
               if (beat_cnt_q == LastBeat) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         StDrain: begin
            bus.mem_rready_o = 1'b1;
            if (bus.mem_rvalid_i) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LastBeat) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.busy_o = (state_q != StIdle);
   assign bus.done_o = done_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         word_idx_q <= '0;
         beat_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_idx_q <= word_idx_d;
         beat_cnt_q <= beat_cnt_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: doc/ucsbece154b_line_fetcher.md
Name: ucsbece154b_line_fetcher

Overview:
- Upstream producer for the instruction/data word FIFO.
- Accepts a cache-line fill request and issues one burst read to the memory model.
- Receives the burst beats in critical-word-first wrap order and pushes each beat into the FIFO, honouring the FIFO's full flag.
- Supports flushing (branch redirect) by draining the outstanding beats without pushing them.

Parameters:
- DATA_WIDTH, 32, width of a memory beat and of a FIFO entry.
- ADDR_WIDTH, 32, byte address width.
- WORDS_PER_LINE, 4, beats per burst; must be a power of 2 and at least 2.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- req_valid_i  input  1  line-fill request valid.
- req_ready_o  output  1  fetcher can accept a request.
- req_addr_i  input  ADDR_WIDTH  byte address of the critical word.
- flush_i  input  1  abort the current fill.
- mem_req_o  output  1  burst read request to memory.
- mem_addr_o  output  ADDR_WIDTH  word-aligned critical-word address.
- mem_ack_i  input  1  memory accepted the burst request.
- mem_rvalid_i  input  1  beat valid.
- mem_rready_o  output  1  fetcher accepts a beat.
- mem_rdata_i  input  DATA_WIDTH  beat data.
- fifo_data_o  output  DATA_WIDTH  data pushed to the FIFO.
- fifo_push_o  output  1  push strobe; connects to the FIFO's push_i.
- fifo_full_i  input  1  from the FIFO's full_o.
- word_idx_o  output  clog2(WORDS_PER_LINE)  word offset within the line of the current push.
- busy_o  output  1  state is not IDLE.
- done_o  output  1  one-cycle pulse after the last beat of a non-flushed fill has been pushed.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to IDLE.
  - beat_cnt, word_idx and the address register clear to 0.
  - done_o is 0.
  - All combinational outputs then take their IDLE values: req_ready_o=1, everything else 0.
  - Reset during any state (including mid-burst) applies the same way.
- Offset fields:
  - OFF = clog2(WORDS_PER_LINE).
  - The word offset is addr[OFF+1:2].
  - The byte bits [1:0] are ignored and forced to 0 on mem_addr_o.
- State IDLE:
  - req_ready_o = !flush_i.
  - When req_valid_i && req_ready_o: register the address and the start offset, then go to ADDR.
- State ADDR:
  - mem_req_o = 1, mem_addr_o = the registered word-aligned address, held stable until ack.
  - If mem_ack_i: go to DATA with beat_cnt=0 and word_idx=start offset. This holds even when flush_i is high; in that case go to DRAIN instead, because the burst is committed.
  - If flush_i && !mem_ack_i: go to IDLE. mem_req_o drops in the next cycle.
- State DATA:
  - mem_rready_o = !fifo_full_i && !flush_i.
  - A beat is taken when mem_rvalid_i && mem_rready_o. In that cycle: fifo_push_o=1 and fifo_data_o=mem_rdata_i, both combinational and the same cycle as the beat.
  - On each taken beat:
    - word_idx_o reports the current index.
    - beat_cnt increments.
    - word_idx increments modulo WORDS_PER_LINE.
  - fifo_push_o never asserts while fifo_full_i=1. A push-with-pop on a full FIFO is not used.
  - When the last beat is taken (beat_cnt==WORDS_PER_LINE-1): go to IDLE and register done_o=1 for the next cycle.
  - If flush_i: go to DRAIN. Any beat present in that cycle is not pushed and not counted.
- State DRAIN:
  - mem_rready_o=1 and fifo_push_o=0.
  - Each beat with mem_rvalid_i counts.
  - When the count reaches WORDS_PER_LINE: go to IDLE. done_o is not asserted.
  - flush_i has no further effect.
- Latency:
  - Request accepted at cycle t gives mem_req_o at t+1.
  - First push happens in the same cycle as the first beat.
  - done_o is high in the cycle in which IDLE is re-entered, so a new request can be accepted in that cycle.
- Counter widths:
  - beat_cnt is OFF+1 bits.
  - Address arithmetic is pure bit selection; no adders on the address.
- While fifo_full_i=1, beats are back-pressured indefinitely. Memory must hold mem_rdata_i until it is accepted.

Decomposition:
- Package ucsbece154b_line_fetcher_pkg contains:
  - the state enum typedef (IDLE, ADDR, DATA, DRAIN), 2 bits;
  - a localparam function for the offset width.
- No sub-module. This is a single FSM with counters.

Test Plan:
- Reset, then request 0x0000_1008 with memory returning A,B,C,D on consecutive cycles -> mem_addr_o=0x1008; 4 consecutive pushes A,B,C,D with word_idx_o 2,3,0,1; done_o is high exactly one cycle after D; busy_o then falls to 0.
- Same fill with fifo_full_i high for beats 2–3 -> mem_rready_o=0 and no push during those cycles; pushes are A,B,C,D in order with no duplicates; done_o asserts once.
- flush_i asserted after beat A -> B,C,D are accepted with fifo_push_o=0; IDLE after D; done_o stays 0.
- flush_i in ADDR without ack -> mem_req_o=0 and req_ready_o=1 the next cycle. flush_i coincident with mem_ack_i -> DRAIN of 4 beats, no pushes.
- req_valid_i held high across two fills -> the second request is accepted in the done_o cycle; its mem_req_o follows one cycle later.
- rst_i pulsed after beat B -> at the next edge all outputs are at their IDLE reset values; a fresh request then completes normally.
